dmem_dump_responder: RTL and testbench

Data-memory responder for the pipelined RV32I core's dmem port. It holds a byte-addressed little-endian store with a combinational read and a synchronous write. When a halt is requested, it streams the first `DUMP_WORDS` words out over a valid/ready port, which lets answer-key comparison run in hardware instead of through hierarchical testbench access. It sits between the core's dmem port and a checker/UART bridge.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_dump_responder_if.sv | 31 +++
 rtl/dmem_dump_responder_byte_array.sv | 64 ++++++
 rtl/dmem_dump_responder.sv | 87 ++++++++
 tb/tb_dmem_dump_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and the dump FSM state type for the data-memory
// responder slice.
//   ADDR_WIDTH / WORD_WIDTH : default dmem bus widths
//   BYTE_WIDTH              : storage granule (bytes are 8 bits)
//   dump_state_e            : IDLE -> DUMP -> DONE
package dmem_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    DONE
  } dump_state_e;

endpackage

// File: rtl/dmem_dump_responder_if.sv
// dmem_dump_responder_if: bundles the core dmem port and the dump stream.
//   master : core/checker side (drives address, write data, halt, ready)
//   slave  : responder side (drives read data, dump beat and status)
interface dmem_dump_responder_if #(
  parameter int unsigned ADDR_WIDTH = dmem_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = dmem_pkg::WORD_WIDTH
);

  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [WORD_WIDTH-1:0] dmem_data_in;
  logic                  dmem_wr_en;
  logic [WORD_WIDTH-1:0] dmem_data_out;
  logic                  halt_req;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic [WORD_WIDTH-1:0] dump_data;
  logic                  dump_done;
  logic                  busy;

  modport master (
    output dmem_addr, dmem_data_in, dmem_wr_en, halt_req, dump_ready,
    input  dmem_data_out, dump_valid, dump_addr, dump_data, dump_done, busy
  );

  modport slave (
    input  dmem_addr, dmem_data_in, dmem_wr_en, halt_req, dump_ready,
    output dmem_data_out, dump_valid, dump_addr, dump_data, dump_done, busy
  );

endinterface

// File: rtl/dmem_dump_responder_byte_array.sv
// dmem_byte_array: byte-addressed little-endian storage.
//   clk                : write clock
//   wr_en/wr_addr/wr_data : full-word synchronous write port
//   rd_a_addr/rd_a_data   : combinational word read (core port)
//   rd_b_addr/rd_b_data   : combinational word read (dump port)
// Low address bits select nothing (word aligned); bits at and above
// log2(MEM_BYTES) are dropped, so addresses alias modulo MEM_BYTES.
// Storage powers up zeroed and is never cleared by reset.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = dmem_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = dmem_pkg::WORD_WIDTH,
  parameter int unsigned MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_a_addr,
  output logic [WORD_WIDTH-1:0] rd_a_data,
  input  logic [ADDR_WIDTH-1:0] rd_b_addr,
  output logic [WORD_WIDTH-1:0] rd_b_data
);

  localparam int unsigned IDX_W = $clog2(MEM_BYTES);
  localparam int unsigned BPW   = WORD_WIDTH / BYTE_WIDTH;
  localparam int unsigned OFF_W = $clog2(BPW);

  logic [BYTE_WIDTH-1:0] mem [MEM_BYTES] = '{default: '0};

  logic [IDX_W-1:0] wr_base;
  logic [IDX_W-1:0] rd_a_base;
  logic [IDX_W-1:0] rd_b_base;

  assign wr_base   = {wr_addr[IDX_W-1:OFF_W],   OFF_W'(0)};
  assign rd_a_base = {rd_a_addr[IDX_W-1:OFF_W], OFF_W'(0)};
  assign rd_b_base = {rd_b_addr[IDX_W-1:OFF_W], OFF_W'(0)};

  // Offset and alias bits are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[ADDR_WIDTH-1:IDX_W],   wr_addr[OFF_W-1:0],
                              rd_a_addr[ADDR_WIDTH-1:IDX_W], rd_a_addr[OFF_W-1:0],
                              rd_b_addr[ADDR_WIDTH-1:IDX_W], rd_b_addr[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < BPW; b++) begin
        mem[wr_base + IDX_W'(b)] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Byte at the lowest address lands in the least significant lane.
  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    for (int unsigned b = 0; b < BPW; b++) begin
      rd_a_data[b*BYTE_WIDTH +: BYTE_WIDTH] = mem[rd_a_base + IDX_W'(b)];
      rd_b_data[b*BYTE_WIDTH +: BYTE_WIDTH] = mem[rd_b_base + IDX_W'(b)];
    end
  end

endmodule

// File: rtl/dmem_dump_responder.sv
// dmem_dump_responder: data-memory responder for the core's dmem port with a
// halt-triggered dump of the first DUMP_WORDS words over valid/ready.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (FSM only; storage is retained)
//   bus : dmem_dump_responder_if.slave
//         core side  : dmem_addr, dmem_data_in, dmem_wr_en -> dmem_data_out
//         dump side  : halt_req, dump_ready -> dump_valid, dump_addr,
//                      dump_data, dump_done, busy
// Writes are accepted only in IDLE, which freezes the image being dumped and
// keeps a stalled beat stable.
module dmem_dump_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = dmem_pkg::ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = dmem_pkg::WORD_WIDTH,
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned DUMP_WORDS = 32
) (
  input logic                clk,
  input logic                rst,
  dmem_dump_responder_if.slave bus
);

  localparam int unsigned PTR_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int unsigned OFF_W = $clog2(WORD_WIDTH / BYTE_WIDTH);

  dump_state_e      state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             wr_gated;
  logic [ADDR_WIDTH-1:0] dump_addr_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (bus.halt_req) begin
          state_nxt = DUMP;
          ptr_nxt   = '0;
        end
      end
      DUMP: begin
        // dump_valid is constant 1 here, so ready alone is the handshake.
        if (bus.dump_ready) begin
          if (ptr == PTR_W'(DUMP_WORDS - 1)) state_nxt = DONE;
          else                               ptr_nxt   = ptr + PTR_W'(1);
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_gated    = bus.dmem_wr_en && (state == IDLE);
  assign dump_addr_w = ADDR_WIDTH'({ptr, OFF_W'(0)});

  assign bus.dump_valid = (state == DUMP);
  assign bus.dump_done  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.dump_addr  = dump_addr_w;

  dmem_byte_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_array (
    .clk       (clk),
    .wr_en     (wr_gated),
    .wr_addr   (bus.dmem_addr),
    .wr_data   (bus.dmem_data_in),
    .rd_a_addr (bus.dmem_addr),
    .rd_a_data (bus.dmem_data_out),
    .rd_b_addr (dump_addr_w),
    .rd_b_data (bus.dump_data)
  );

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Scoreboard bench for dmem_dump_responder: expected dump beats are queued
// when a dump is launched; a negedge monitor compares each presented beat.
module tb_dmem_dump_responder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_dump_responder_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

  dmem_dump_responder #(
    .ADDR_WIDTH (32),
    .WORD_WIDTH (32),
    .MEM_BYTES  (4096),
    .DUMP_WORDS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected image: word i = i*0x01010101, with word 0 overridable.
  task automatic push_dump(input logic [31:0] word0);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.addr = 32'(i * 4);
      b.data = (i == 0) ? word0 : 32'(i) * 32'h0101_0101;
      exp_q.push_back(b);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_addr    = a;
    bus.dmem_data_in = d;
    bus.dmem_wr_en   = 1'b1;
    @(posedge clk); #1;
    bus.dmem_wr_en   = 1'b0;
  endtask

  task automatic pulse_halt();
    bus.halt_req = 1'b1;
    @(posedge clk); #1;
    bus.halt_req = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Counts negedges from the first cycle after the halt edge until done.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.dump_done) break;
    end
  endtask

  task automatic wait_beat_addr(input logic [31:0] a);
    for (int i = 0; i < 64; i++) begin
      if (bus.dump_addr == a) break;
      @(posedge clk); #1;
    end
    chk("beat_reached", bus.dump_addr, a);
  endtask

  // Monitor: every presented beat (stalled or accepted) must match the head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.dump_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got addr 0x%08h expected no beat", bus.dump_addr);
        end else begin
          chk("beat_addr", bus.dump_addr, exp_q[0].addr);
          chk("beat_data", bus.dump_data, exp_q[0].data);
          if (bus.dump_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    rst              = 1'b1;
    bus.dmem_addr    = '0;
    bus.dmem_data_in = '0;
    bus.dmem_wr_en   = 1'b0;
    bus.halt_req     = 1'b0;
    bus.dump_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(bus.dump_valid), 32'd0);
    chk("rst_done",  32'(bus.dump_done),  32'd0);
    chk("rst_busy",  32'(bus.busy),       32'd0);
    chk("rst_addr",  bus.dump_addr,       32'h0);
    chk("rst_data",  bus.dump_data,       32'h0);
    chk("rst_rd0",   bus.dmem_data_out,   32'h0);

    // Write then read, byte order
    do_write(32'h10, 32'hDEAD_BEEF);
    bus.dmem_addr = 32'h10; #1;
    chk("rd_0x10",   bus.dmem_data_out, 32'hDEAD_BEEF);
    chk("byte_0x10", {24'h0, bus.dmem_data_out[7:0]},   32'hEF);
    chk("byte_0x13", {24'h0, bus.dmem_data_out[31:24]}, 32'hDE);

    // Unaligned and aliased reads
    bus.dmem_addr = 32'h13; #1;
    chk("rd_0x13", bus.dmem_data_out, 32'hDEAD_BEEF);
    bus.dmem_addr = 32'h1010; #1;
    chk("rd_alias_0x1010", bus.dmem_data_out, 32'hDEAD_BEEF);

    // Full dump with ready held high
    for (int i = 0; i < 32; i++) do_write(32'(i * 4), 32'(i) * 32'h0101_0101);
    push_dump(32'h0);
    bus.dump_ready = 1'b1;
    pulse_halt();
    chk("start_valid", 32'(bus.dump_valid), 32'd1);
    chk("start_busy",  32'(bus.busy),       32'd1);
    wait_done(n);
    chk("done_latency", 32'(n), 32'd33);
    chk("done_flag",    32'(bus.dump_done),  32'd1);
    chk("done_valid",   32'(bus.dump_valid), 32'd0);
    chk("q_empty_full", 32'(exp_q.size()),   32'd0);
    // Done is sticky and halt is ignored
    pulse_halt();
    @(negedge clk);
    chk("done_sticky",  32'(bus.dump_done),  32'd1);
    chk("done_nohalt",  32'(bus.dump_valid), 32'd0);
    pulse_rst();

    // Backpressure at beat 5 with a blocked write
    push_dump(32'h0);
    pulse_halt();
    wait_beat_addr(32'h14);
    bus.dump_ready   = 1'b0;
    bus.dmem_addr    = 32'h14;
    bus.dmem_data_in = 32'h1234_5678;
    bus.dmem_wr_en   = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("stall_valid", 32'(bus.dump_valid), 32'd1);
    bus.dmem_wr_en = 1'b0;
    bus.dump_ready = 1'b1;
    wait_done(n);
    chk("bp_done",     32'(bus.dump_done), 32'd1);
    chk("q_empty_bp",  32'(exp_q.size()),  32'd0);
    pulse_rst();
    bus.dmem_addr = 32'h14; #1;
    chk("blocked_write", bus.dmem_data_out, 32'h0505_0505);

    // Write in the same cycle as halt
    push_dump(32'hCAFE_F00D);
    bus.dmem_addr    = 32'h0;
    bus.dmem_data_in = 32'hCAFE_F00D;
    bus.dmem_wr_en   = 1'b1;
    pulse_halt();
    bus.dmem_wr_en   = 1'b0;
    wait_done(n);
    chk("wh_latency",  32'(n),             32'd33);
    chk("q_empty_wh",  32'(exp_q.size()),  32'd0);
    pulse_rst();

    // Reset mid-dump at beat 10, then restart
    push_dump(32'hCAFE_F00D);
    pulse_halt();
    wait_beat_addr(32'h28);
    pulse_rst();
    exp_q.delete();
    chk("mid_rst_valid", 32'(bus.dump_valid), 32'd0);
    chk("mid_rst_busy",  32'(bus.busy),       32'd0);
    chk("mid_rst_done",  32'(bus.dump_done),  32'd0);
    chk("mid_rst_addr",  bus.dump_addr,       32'h0);
    chk("mid_rst_data",  bus.dump_data,       32'hCAFE_F00D);
    bus.dmem_addr = 32'h28; #1;
    chk("mid_rst_mem",   bus.dmem_data_out,   32'h0A0A_0A0A);
    push_dump(32'hCAFE_F00D);
    pulse_halt();
    wait_done(n);
    chk("restart_latency", 32'(n),            32'd33);
    chk("q_empty_restart", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
